gnrl_sync_fifo: RTL

GNRL_SYNC_FIFO -- requirements
Module: gnrl_sync_fifo

---
 rtl/gnrl_sync_fifo_pkg.sv | 15 +
 rtl/gnrl_fifo_ptr.sv | 27 ++
 rtl/gnrl_sync_fifo.sv | 80 ++++++++
 3 files changed

// File: rtl/gnrl_sync_fifo_pkg.sv
// Shared FIFO sizing helpers.
// Contents: pointer-width and index-width functions used by the FIFO top.
package gnrl_sync_fifo_pkg;

  // Index width for a power-of-two depth.
  function automatic int unsigned fifo_idx_w(input int unsigned dp);
    return $clog2(dp);
  endfunction

  // Pointer width: index plus one phase bit, so full and empty stay distinguishable.
  function automatic int unsigned fifo_ptr_w(input int unsigned dp);
    return $clog2(dp) + 1;
  endfunction

endpackage

// File: rtl/gnrl_fifo_ptr.sv
// Wrapping FIFO pointer with a phase bit.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low clear
//   inc   - advance the pointer by one this edge
//   ptr   - pointer value, AW index bits plus phase MSB, wraps modulo 2**(AW+1)
module gnrl_fifo_ptr #(
  parameter int unsigned AW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [AW:0] ptr
);

  localparam int unsigned PW = AW + 1;

  // Natural overflow of the PW-bit register gives the modulo-2*DP wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/gnrl_sync_fifo.sv
// Synchronous FIFO with valid/ready handshakes on both sides, one-cycle latency.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   i_vld/i_rdy    - write handshake, i_dat is write data
//   o_vld/o_rdy    - read handshake, o_dat is the head entry
//   count          - current occupancy, 0..DP
module gnrl_sync_fifo
  import gnrl_sync_fifo_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned DP = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_vld,
  output logic                 i_rdy,
  input  logic [DW-1:0]        i_dat,
  output logic                 o_vld,
  input  logic                 o_rdy,
  output logic [DW-1:0]        o_dat,
  output logic [$clog2(DP):0]  count
);

  localparam int unsigned AW = fifo_idx_w(DP);
  localparam int unsigned PW = fifo_ptr_w(DP);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] mem [DP];
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Full/empty come only from registered pointers, so the ready/valid
  // outputs never see the opposite side's handshake inputs.
  always_comb begin
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    empty = (wr_ptr == rd_ptr);
    i_rdy = !full;
    o_vld = !empty;
    push  = i_vld && i_rdy;
    pop   = o_vld && o_rdy;
  end

  gnrl_fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  gnrl_fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately not reset; only pushes write it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= i_dat;
    end
  end

  assign o_dat = mem[rd_ptr[AW-1:0]];

  // Occupancy counter; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + PW'(1);
    end else if (pop && !push) begin
      count <= count - PW'(1);
    end
  end

endmodule
